// File: rtl/tt_um_nitelich_riscy_jr_if.sv
// Tile pin bundle for the RISCy Jr core: fetch bus, data I/O port and tile enable.
// Purely combinational wiring; the core side owns all registered outputs.
interface tt_um_nitelich_riscy_jr_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_nitelich_riscy_jr.sv
// RISCy Jr: 8-bit core, 4 regs, Z/C flags, PC on uo_out, instruction combinationally on ui_in.
// Latency: one instruction per clock, results visible the following cycle.
// Backpressure: ena=0 (or HALT) freezes every piece of architectural state.
module tt_um_nitelich_riscy_jr (
    input  logic                          clk,
    input  logic                          rst_n,
    tt_um_nitelich_riscy_jr_if.slave      io
);

    logic [7:0]      pc_q, pc_d;
    logic [3:0][7:0] rf_q, rf_d;
    logic            z_q, z_d;
    logic            c_q, c_d;
    logic            halted_q, halted_d;
    logic [7:0]      uio_out_q, uio_out_d;
    logic [7:0]      uio_oe_q, uio_oe_d;

    logic [7:0] instr;
    logic [1:0] rd, rs;
    logic [7:0] op_a, op_b;
    logic [7:0] res;
    logic [8:0] wide;
    logic       upd_z;
    logic       taken;

    assign instr = io.ui_in;
    assign rd    = instr[3:2];
    assign rs    = instr[1:0];
    assign op_a  = rf_q[rd];
    assign op_b  = rf_q[rs];

    always_comb begin
        pc_d      = pc_q;
        rf_d      = rf_q;
        z_d       = z_q;
        c_d       = c_q;
        halted_d  = halted_q;
        uio_out_d = uio_out_q;
        uio_oe_d  = uio_oe_q;
        res       = '0;
        wide      = '0;
        upd_z     = 1'b0;
        taken     = 1'b0;

        if (io.ena && !halted_q) begin
            pc_d = pc_q + 8'd1;
            unique case (instr[7:6])
                2'b00: rf_d[instr[5:4]] = {4'b0000, instr[3:0]};
                2'b01: begin
                    unique case (instr[5:4])
                        2'b00: begin
                            wide = {1'b0, op_a} + {1'b0, op_b};
                            c_d  = wide[8];
                            res  = wide[7:0];
                        end
                        // Bit 8 of the 9-bit difference is the unsigned borrow.
                        2'b01: begin
                            wide = {1'b0, op_a} - {1'b0, op_b};
                            c_d  = wide[8];
                            res  = wide[7:0];
                        end
                        2'b10: begin
                            res = op_a & op_b;
                            c_d = 1'b0;
                        end
                        default: begin
                            res = op_a ^ op_b;
                            c_d = 1'b0;
                        end
                    endcase
                    rf_d[rd] = res;
                    upd_z    = 1'b1;
                end
                2'b10: begin
                    unique case (instr[5:4])
                        2'b00:   taken = 1'b1;
                        2'b01:   taken = z_q;
                        2'b10:   taken = !z_q;
                        default: taken = c_q;
                    endcase
                    if (taken)
                        pc_d = pc_q + {{4{instr[3]}}, instr[3:0]};
                end
                default: begin
                    unique case (instr[5:4])
                        2'b00: rf_d[rd] = op_b;
                        2'b01: begin
                            rf_d[rd] = io.uio_in;
                            uio_oe_d = 8'h00;
                        end
                        2'b10: begin
                            uio_out_d = op_b;
                            uio_oe_d  = 8'hFF;
                        end
                        default: begin
                            unique case (rs)
                                2'b00: begin
                                    c_d = op_a[7];
                                    res = {op_a[6:0], 1'b0};
                                end
                                2'b01: begin
                                    c_d = op_a[0];
                                    res = {1'b0, op_a[7:1]};
                                end
                                2'b10: begin
                                    wide = {1'b0, op_a} + 9'd1;
                                    c_d  = wide[8];
                                    res  = wide[7:0];
                                end
                                default: ;
                            endcase
                            if (rs == 2'b11) begin
                                halted_d = 1'b1;
                                pc_d     = pc_q;
                            end else begin
                                rf_d[rd] = res;
                                upd_z    = 1'b1;
                            end
                        end
                    endcase
                end
            endcase
            if (upd_z)
                z_d = (res == 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            rf_q      <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            halted_q  <= 1'b0;
            uio_out_q <= '0;
            uio_oe_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            rf_q      <= rf_d;
            z_q       <= z_d;
            c_q       <= c_d;
            halted_q  <= halted_d;
            uio_out_q <= uio_out_d;
            uio_oe_q  <= uio_oe_d;
        end
    end

    assign io.uo_out  = pc_q;
    assign io.uio_out = uio_out_q;
    assign io.uio_oe  = uio_oe_q;

endmodule

// File: tb/tb_tt_um_nitelich_riscy_jr.sv
// Directed bench for RISCy Jr: program memory model drives ui_in from the PC on uo_out.
module tb_tt_um_nitelich_riscy_jr;

    logic clk;
    logic rst_n;
    logic [7:0] prog [256];
    int n_checks;
    int n_pass;

    tt_um_nitelich_riscy_jr_if ifc ();

    tt_um_nitelich_riscy_jr dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc.slave)
    );

    assign ifc.ui_in = prog[ifc.uo_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) prog[i] = v;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_core();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        ifc.ena    = 1'b1;
        ifc.uio_in = 8'h00;
        fill(8'h00);

        // Reset state, then sequential fetch and wrap
        #12;
        chk("rst_pc", ifc.uo_out, 8'h00);
        chk("rst_uio_out", ifc.uio_out, 8'h00);
        chk("rst_uio_oe", ifc.uio_oe, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1); chk("seq_pc1", ifc.uo_out, 8'h01);
        step(1); chk("seq_pc2", ifc.uo_out, 8'h02);
        step(1); chk("seq_pc3", ifc.uo_out, 8'h03);
        step(253); chk("pc_wrap", ifc.uo_out, 8'h00);

        // LDI/ADD/OUT
        fill(8'hFF);
        prog[0] = 8'h15; prog[1] = 8'h23; prog[2] = 8'h46; prog[3] = 8'hE1;
        reset_core();
        step(4);
        chk("add_out", ifc.uio_out, 8'h08);
        chk("add_oe", ifc.uio_oe, 8'hFF);
        chk("add_pc", ifc.uo_out, 8'h04);

        // SUB loop with BNZ, then BZ on exit
        fill(8'hFF);
        prog[0] = 8'h03; prog[1] = 8'h11; prog[2] = 8'h51; prog[3] = 8'hAF;
        prog[4] = 8'h92;
        reset_core();
        step(1); chk("loop_pc_e1", ifc.uo_out, 8'h01);
        step(1); chk("loop_pc_e2", ifc.uo_out, 8'h02);
        step(1); chk("loop_pc_e3", ifc.uo_out, 8'h03);
        step(1); chk("loop_pc_e4", ifc.uo_out, 8'h02);
        step(1); chk("loop_pc_e5", ifc.uo_out, 8'h03);
        step(1); chk("loop_pc_e6", ifc.uo_out, 8'h02);
        step(1); chk("loop_pc_e7", ifc.uo_out, 8'h03);
        step(1); chk("loop_pc_e8", ifc.uo_out, 8'h04);
        step(1); chk("loop_bz_z1", ifc.uo_out, 8'h06);

        // OUT / IN / OUT direction switching
        fill(8'hFF);
        prog[0] = 8'hE0; prog[1] = 8'hDC; prog[2] = 8'hE3;
        ifc.uio_in = 8'hA5;
        reset_core();
        step(1);
        chk("io_oe_out", ifc.uio_oe, 8'hFF);
        chk("io_val_r0", ifc.uio_out, 8'h00);
        step(1); chk("io_oe_in", ifc.uio_oe, 8'h00);
        step(1);
        chk("io_oe_out2", ifc.uio_oe, 8'hFF);
        chk("io_val_in", ifc.uio_out, 8'hA5);
        ifc.uio_in = 8'h00;

        // Borrow, INC wrap with carry, conditional branches on C and Z
        fill(8'hFF);
        prog[0]  = 8'h11; prog[1]  = 8'h55; prog[2]  = 8'hB2; prog[3] = 8'h11;
        prog[4]  = 8'h20; prog[5]  = 8'h59; prog[6]  = 8'hE2; prog[7] = 8'hFA;
        prog[8]  = 8'hB3; prog[11] = 8'hE2; prog[12] = 8'h92;
        reset_core();
        step(3); chk("bc_not_taken", ifc.uo_out, 8'h03);
        step(4); chk("sub_borrow_val", ifc.uio_out, 8'hFF);
        step(2); chk("inc_bc_taken", ifc.uo_out, 8'h0B);
        step(1); chk("inc_wrap_val", ifc.uio_out, 8'h00);
        step(1); chk("inc_bz_taken", ifc.uo_out, 8'h0E);
        step(2); chk("halt_after_bz", ifc.uo_out, 8'h0E);

        // AND, XOR self-clear, SHL/SHR
        fill(8'hFF);
        prog[0]  = 8'h0F; prog[1]  = 8'h19; prog[2]  = 8'h61; prog[3] = 8'hE0;
        prog[4]  = 8'h75; prog[5]  = 8'h92; prog[7]  = 8'h29; prog[8] = 8'hF8;
        prog[9]  = 8'hF8; prog[10] = 8'hE2; prog[11] = 8'hF9; prog[12] = 8'hE2;
        reset_core();
        step(4); chk("and_val", ifc.uio_out, 8'h09);
        step(2); chk("xor_self_bz", ifc.uo_out, 8'h07);
        step(4); chk("shl_val", ifc.uio_out, 8'h24);
        step(2); chk("shr_val", ifc.uio_out, 8'h12);
        step(1); chk("alu_halt_pc", ifc.uo_out, 8'h0D);

        // HALT holds PC
        fill(8'h00);
        prog[2] = 8'hFF;
        reset_core();
        step(2);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk($sformatf("halt_hold_%0d", i), ifc.uo_out, 8'h02);
        end

        // ena=0 stall, then async reset mid-program
        fill(8'h00);
        prog[0] = 8'h15; prog[1] = 8'hE1; prog[2] = 8'hDC; prog[3] = 8'hE3;
        ifc.uio_in = 8'h3C;
        reset_core();
        step(2);
        chk("ena_pre_pc", ifc.uo_out, 8'h02);
        @(negedge clk);
        ifc.ena = 1'b0;
        step(5);
        chk("ena_hold_pc", ifc.uo_out, 8'h02);
        chk("ena_hold_out", ifc.uio_out, 8'h05);
        chk("ena_hold_oe", ifc.uio_oe, 8'hFF);
        @(negedge clk);
        ifc.ena = 1'b1;
        step(1);
        chk("ena_resume_pc", ifc.uo_out, 8'h03);
        chk("ena_resume_oe", ifc.uio_oe, 8'h00);
        step(1);
        chk("ena_resume_out", ifc.uio_out, 8'h3C);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", ifc.uo_out, 8'h00);
        chk("async_rst_out", ifc.uio_out, 8'h00);
        chk("async_rst_oe", ifc.uio_oe, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        chk("restart_pc", ifc.uo_out, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
